// File: rtl/mux_stim_sequencer.sv
// mux_stim_sequencer: on-board self-test stimulus stage for the 2:1 mux.
// Steps {S,I1,I0} through 0..7, samples the mux probe bus after a dwell,
// and keeps a saturating error count plus first-failure bookkeeping.
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   start           level, sampled in IDLE; high launches a pass
//   continuous      1 = loop passes, sampled at the last vector's sample
//   probe[8:0]      [8] = mux output, [2:0] = echoed {S,I1,I0}
//   stim_s/i0/i1    registered drives to the mux
//   busy, done      pass in progress / one-cycle end-of-pass pulse
//   vec_idx         vector currently driven ({S,I1,I0})
//   err_cnt         saturating mismatch count since launch
//   err_flag        sticky first-mismatch flag
//   first_fail_idx  vec_idx of the first mismatch since launch
//   last_probe      probe captured at the most recent sample
module mux_stim_sequencer #(
    parameter int DWELL_CYCLES = 4,
    parameter int ERR_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic [8:0]       probe,
    output logic             stim_s,
    output logic             stim_i0,
    output logic             stim_i1,
    output logic             busy,
    output logic             done,
    output logic [2:0]       vec_idx,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [2:0]       first_fail_idx,
    output logic [8:0]       last_probe
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);

    state_t     state;
    state_t     state_d;
    logic [7:0] dwell;
    logic       expect_out;
    logic       mism;

    // vec_idx is a register and returns to 0 in IDLE, so the stim
    // drives are registered and read 000 whenever no pass runs.
    assign {stim_s, stim_i1, stim_i0} = vec_idx;
    assign busy = (state != IDLE);

    assign expect_out = stim_s ? stim_i1 : stim_i0;
    assign mism = (probe[8] != expect_out) ||
                  (probe[2:0] != vec_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (dwell == DWELL_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (vec_idx != 3'd7 || continuous) begin
                    state_d = DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell          <= '0;
            vec_idx        <= '0;
            done           <= 1'b0;
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_fail_idx <= '0;
            last_probe     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dwell          <= '0;
                        vec_idx        <= '0;
                        err_cnt        <= '0;
                        err_flag       <= 1'b0;
                        first_fail_idx <= '0;
                    end
                end
                DRIVE: begin
                    dwell <= dwell + 8'd1;
                end
                SAMPLE: begin
                    last_probe <= probe;
                    if (mism) begin
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERR_W'(1);
                        end
                        if (!err_flag) begin
                            err_flag       <= 1'b1;
                            first_fail_idx <= vec_idx;
                        end
                    end
                    dwell <= '0;
                    // 7 wraps to 0: restart vector for a looping
                    // pass and the idle value for a single pass.
                    vec_idx <= vec_idx + 3'd1;
                    if (vec_idx == 3'd7) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_stim_sequencer.sv
// Bench for mux_stim_sequencer: two instances (dwell 4 and dwell 1)
// against a cycle-count model plus directed literal expectations.
module tb_mux_stim_sequencer;

    localparam int D0 = 4;
    localparam int D1 = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       continuous;
    int         mode;

    logic [8:0] probe_w   [2];
    logic [1:0] s_w, i0_w, i1_w, busy_w, done_w, flag_w;
    logic [2:0] vidx_w    [2];
    logic [3:0] err_w     [2];
    logic [2:0] ffi_w     [2];
    logic [8:0] lp_w      [2];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int t0   = 0;
    int dcnt [2] = '{0, 0};
    int dcyc [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode 0 ideal, 1 faulty output, 2 echo bit [2] stuck low
    function automatic logic [8:0] stub(input int md,
                                        input logic [2:0] v);
        logic       o;
        logic [2:0] e;
        o = v[2] ? v[1] : v[0];
        e = v;
        if (md == 1) o = v[1] | (v[0] & ~v[2]);
        if (md == 2) e[2] = 1'b0;
        return {o, 5'b0, e};
    endfunction

    assign probe_w[0] = stub(mode, {s_w[0], i1_w[0], i0_w[0]});
    assign probe_w[1] = stub(mode, {s_w[1], i1_w[1], i0_w[1]});

    mux_stim_sequencer #(.DWELL_CYCLES(D0), .ERR_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .continuous(continuous), .probe(probe_w[0]),
        .stim_s(s_w[0]), .stim_i0(i0_w[0]), .stim_i1(i1_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .vec_idx(vidx_w[0]),
        .err_cnt(err_w[0]), .err_flag(flag_w[0]),
        .first_fail_idx(ffi_w[0]), .last_probe(lp_w[0])
    );

    mux_stim_sequencer #(.DWELL_CYCLES(D1), .ERR_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .continuous(continuous), .probe(probe_w[1]),
        .stim_s(s_w[1]), .stim_i0(i0_w[1]), .stim_i1(i1_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .vec_idx(vidx_w[1]),
        .err_cnt(err_w[1]), .err_flag(flag_w[1]),
        .first_fail_idx(ffi_w[1]), .last_probe(lp_w[1])
    );

    task automatic chk(input string nm, input int u,
                       input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0h want %0h at cycle %0d",
                     nm, u, act, exp, cyc);
        end
    endtask

    function automatic int per(input int u);
        return (u == 0) ? D0 + 1 : D1 + 1;
    endfunction

    // Model: position inside a pass is a plain cycle count n since
    // launch; vector = n / period, sample of vector k lands on
    // n = (k+1)*period, done on n = 8*period.
    logic       m_busy [2];
    logic       m_done [2];
    logic       m_flag [2];
    int         m_n    [2];
    int         m_err  [2];
    int         m_ffi  [2];
    logic [8:0] m_lp   [2];

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_busy[u] = 1'b0; m_done[u] = 1'b0;
                m_flag[u] = 1'b0; m_n[u] = 0; m_err[u] = 0;
                m_ffi[u] = 0; m_lp[u] = '0;
            end else begin
                m_done[u] = 1'b0;
                if (!m_busy[u]) begin
                    if (start) begin
                        m_busy[u] = 1'b1; m_n[u] = 0;
                        m_err[u] = 0; m_flag[u] = 1'b0;
                        m_ffi[u] = 0;
                    end
                end else begin
                    m_n[u]++;
                    if (m_n[u] % per(u) == 0) begin
                        int         k;
                        logic [8:0] pv;
                        k = m_n[u] / per(u) - 1;
                        pv = stub(mode, 3'(k));
                        m_lp[u] = pv;
                        if (pv != stub(0, 3'(k))) begin
                            if (m_err[u] < 15) m_err[u]++;
                            if (!m_flag[u]) begin
                                m_flag[u] = 1'b1;
                                m_ffi[u] = k;
                            end
                        end
                        if (k == 7) begin
                            m_done[u] = 1'b1;
                            if (continuous) m_n[u] = 0;
                            else m_busy[u] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int ev;
            ev = m_busy[u] ? m_n[u] / per(u) : 0;
            chk("busy", u, busy_w[u], m_busy[u]);
            chk("done", u, done_w[u], m_done[u]);
            chk("vec_idx", u, vidx_w[u], ev);
            chk("stim", u, {s_w[u], i1_w[u], i0_w[u]}, ev);
            chk("err_cnt", u, err_w[u], m_err[u]);
            chk("err_flag", u, flag_w[u], m_flag[u]);
            chk("first_fail", u, ffi_w[u], m_ffi[u]);
            chk("last_probe", u, lp_w[u], m_lp[u]);
            if (done_w[u]) begin
                dcnt[u]++;
                dcyc[u] = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_idle(input int u, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (!busy_w[u]) break;
            step();
        end
        chk("idle_timeout", u, busy_w[u], 1'b0);
    endtask

    task automatic wait_dones(input int base, input int n);
        for (int i = 0; i < 2000; i++) begin
            if (dcnt[0] - base >= n) break;
            step();
        end
        chk("done_count", 0, dcnt[0] - base, n);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; mode = 0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // ideal single pass
        pulse_start();
        wait_idle(0, 100);
        chk("done_at_busy_fall", 0, done_w[0], 1'b1);
        chk("done_time", 0, dcyc[0] - t0, 40);
        chk("done_time_d1", 1, dcyc[1] - t0, 16);
        chk("ideal_err", 0, err_w[0], 4'd0);
        chk("ideal_flag", 0, flag_w[0], 1'b0);
        chk("ideal_lp", 0, lp_w[0][2:0], 3'b111);

        // faulty output, single pass
        mode = 1;
        pulse_start();
        wait_idle(0, 100);
        chk("fault_err", 0, err_w[0], 4'd1);
        chk("fault_flag", 0, flag_w[0], 1'b1);
        chk("fault_ffi", 0, ffi_w[0], 3'd2);
        chk("fault_lp8", 0, lp_w[0][8], 1'b1);

        // echo fault
        mode = 2;
        step();
        pulse_start();
        wait_idle(0, 100);
        chk("echo_err", 0, err_w[0], 4'd4);
        chk("echo_ffi", 0, ffi_w[0], 3'd4);

        // continuous with faulty output
        mode = 1;
        continuous = 1'b1;
        d0 = dcnt[0];
        pulse_start();
        wait_dones(d0, 3);
        chk("cont3_err", 0, err_w[0], 4'd3);
        wait_dones(d0, 16);
        chk("cont16_err", 0, err_w[0], 4'd15);
        repeat (20) step();
        continuous = 1'b0;
        wait_idle(0, 100);
        chk("cont_passes", 0, dcnt[0] - d0, 17);
        chk("cont_done_end", 0, done_w[0], 1'b1);
        wait_idle(1, 100);
        step();

        // start held through a whole pass, relaunch after done
        start = 1'b1;
        step();
        t0 = cyc;
        wait_idle(0, 100);
        chk("held_done_time", 0, dcyc[0] - t0, 40);
        chk("held_err", 0, err_w[0], 4'd1);
        step();
        start = 1'b0;
        chk("relaunch_busy", 0, busy_w[0], 1'b1);
        chk("relaunch_err", 0, err_w[0], 4'd0);
        chk("relaunch_vec", 0, vidx_w[0], 3'd0);
        wait_idle(0, 100);
        wait_idle(1, 100);

        // async reset mid-pass at vector 5
        mode = 1;
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            if (vidx_w[0] == 3'd5) break;
            step();
        end
        chk("reach_vec5", 0, vidx_w[0], 3'd5);
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", u, busy_w[u], 1'b0);
            chk("rst_done", u, done_w[u], 1'b0);
            chk("rst_vec", u, vidx_w[u], 3'd0);
            chk("rst_stim", u, {s_w[u], i1_w[u], i0_w[u]}, 3'd0);
            chk("rst_err", u, err_w[u], 4'd0);
            chk("rst_flag", u, flag_w[u], 1'b0);
            chk("rst_ffi", u, ffi_w[u], 3'd0);
            chk("rst_lp", u, lp_w[u], 9'd0);
        end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_idle", 0, busy_w[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
